spatz_vlsu_addrgen: RTL

//   Multi-port address/strobe generator for the vector LSU. Accepts one vector memory op
//   (unit-stride or strided; element width 8/16/32/64 bit) and emits per-port request beats
//   (word address, byte strobes, last) with independent valid/ready per port.

---
 rtl/spatz_vlsu_addrgen.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/spatz_vlsu_addrgen.sv
// Vector LSU address/strobe generator: expands one unit-stride or strided op into per-port word beats.
// Latency: first beat one cycle after accept; per-port valid/ready backpressure, ports advance independently.
module spatz_vlsu_addrgen #(
    parameter int unsigned NrMemPorts = 4,
    parameter int unsigned ElenB      = 4,
    parameter int unsigned VlWidth    = 16,
    parameter int unsigned AddrWidth  = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [AddrWidth-1:0]            req_base_i,
    input  logic [AddrWidth-1:0]            req_stride_i,
    input  logic                            req_strided_i,
    input  logic [VlWidth-1:0]              req_vl_i,
    input  logic [1:0]                      req_vsew_i,
    output logic [NrMemPorts-1:0]           port_valid_o,
    input  logic [NrMemPorts-1:0]           port_ready_i,
    output logic [NrMemPorts*AddrWidth-1:0] port_addr_o,
    output logic [NrMemPorts*ElenB-1:0]     port_strb_o,
    output logic [NrMemPorts-1:0]           port_last_o,
    output logic                            busy_o,
    output logic                            done_o
);
    localparam int unsigned LB = $clog2(ElenB);
    localparam int unsigned LP = $clog2(NrMemPorts);
    localparam int unsigned PW = (LP > 0) ? LP : 1;
    localparam int unsigned CW = VlWidth + 3;
    localparam int unsigned MW = 2 * ElenB;

    typedef enum logic {IDLE, RUN} state_e;

    state_e                 state_q, state_d;
    logic                   word_q, word_d;
    logic [1:0]             vsew_q, vsew_d;
    logic [AddrWidth-1:0]   inc_q, inc_d;
    logic [ElenB-1:0]       tail_q, tail_d;
    logic [PW-1:0]          fin_q, fin_d;
    logic                   done_q, done_d;
    logic [NrMemPorts-1:0]  valid_q, valid_d, last_q, last_d;
    logic [AddrWidth-1:0]   cur_q  [NrMemPorts];
    logic [AddrWidth-1:0]   cur_d  [NrMemPorts];
    logic [AddrWidth-1:0]   addr_q [NrMemPorts];
    logic [AddrWidth-1:0]   addr_d [NrMemPorts];
    logic [CW-1:0]          cnt_q  [NrMemPorts];
    logic [CW-1:0]          cnt_d  [NrMemPorts];
    logic [ElenB-1:0]       strb_q [NrMemPorts];
    logic [ElenB-1:0]       strb_d [NrMemPorts];

    // Only the globally final word of a word-mode op carries a partial strobe.
    function automatic logic [ElenB-1:0] beat_strb(input logic word, input logic [1:0] vsew,
                                                   input logic [ElenB-1:0] tail,
                                                   input logic is_final, input logic [LB-1:0] off);
        logic [7:0]    emask;
        logic [MW-1:0] m;
        case (vsew)
            2'd0:    emask = 8'h01;
            2'd1:    emask = 8'h03;
            2'd2:    emask = 8'h0F;
            default: emask = 8'hFF;
        endcase
        m = MW'(emask) << off;
        if (word) return is_final ? tail : '1;
        return m[ElenB-1:0];
    endfunction

    always_comb begin
        logic [CW-1:0]        bytes, nbeats, bmod, n;
        logic [AddrWidth-1:0] step, acc;
        logic                 word;
        bytes  = CW'(req_vl_i) << req_vsew_i;
        word   = !req_strided_i && (req_base_i[LB-1:0] == '0);
        nbeats = word ? ((bytes + CW'(ElenB - 1)) >> LB) : CW'(req_vl_i);
        bmod   = bytes & CW'(ElenB - 1);
        step   = word ? AddrWidth'(ElenB)
                      : (req_strided_i ? req_stride_i : (AddrWidth'(1) << req_vsew_i));
        acc    = req_base_i;
        n      = '0;

        state_d = state_q;
        word_d  = word_q;
        vsew_d  = vsew_q;
        inc_d   = inc_q;
        tail_d  = tail_q;
        fin_d   = fin_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        last_d  = last_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        strb_d  = strb_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    word_d = word;
                    vsew_d = req_vsew_i;
                    inc_d  = step << LP;
                    tail_d = (bmod == '0) ? '1 : ~({ElenB{1'b1}} << bmod[LB-1:0]);
                    fin_d  = PW'((nbeats - CW'(1)) & CW'(NrMemPorts - 1));
                    if (req_vl_i == '0) done_d  = 1'b1;
                    else                state_d = RUN;
                    // Per-port start addresses come from a running sum, not a multiply.
                    for (int i = 0; i < NrMemPorts; i++) begin
                        n = (nbeats >> LP)
                          + ((CW'(i) < (nbeats & CW'(NrMemPorts - 1))) ? CW'(1) : CW'(0));
                        cur_d[i]   = acc;
                        cnt_d[i]   = n;
                        valid_d[i] = (n != '0);
                        last_d[i]  = (n == CW'(1));
                        addr_d[i]  = acc & ~AddrWidth'(ElenB - 1);
                        strb_d[i]  = beat_strb(word, req_vsew_i, tail_d,
                                               last_d[i] && (PW'(i) == fin_d), acc[LB-1:0]);
                        acc        = acc + step;
                    end
                end
            end
            RUN: begin
                for (int i = 0; i < NrMemPorts; i++) begin
                    if (valid_q[i] && port_ready_i[i]) begin
                        if (cnt_q[i] == CW'(1)) begin
                            valid_d[i] = 1'b0;
                            last_d[i]  = 1'b0;
                        end else begin
                            cur_d[i]   = cur_q[i] + inc_q;
                            cnt_d[i]   = cnt_q[i] - CW'(1);
                            last_d[i]  = (cnt_d[i] == CW'(1));
                            addr_d[i]  = cur_d[i] & ~AddrWidth'(ElenB - 1);
                            strb_d[i]  = beat_strb(word_q, vsew_q, tail_q,
                                                   last_d[i] && (PW'(i) == fin_q), cur_d[i][LB-1:0]);
                        end
                    end
                end
                if (valid_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            word_q  <= 1'b0;
            vsew_q  <= '0;
            inc_q   <= '0;
            tail_q  <= '0;
            fin_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < NrMemPorts; i++) begin
                cur_q[i]  <= '0;
                cnt_q[i]  <= '0;
                addr_q[i] <= '0;
                strb_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            vsew_q  <= vsew_d;
            inc_q   <= inc_d;
            tail_q  <= tail_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
        end
    end

    for (genvar g = 0; g < NrMemPorts; g++) begin : gen_port
        assign port_addr_o[g*AddrWidth +: AddrWidth] = addr_q[g];
        assign port_strb_o[g*ElenB +: ElenB]         = strb_q[g];

        // An element must fit inside one port word.
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            (valid_q[g] && !word_q) |->
            ((32'(cur_q[g][LB-1:0]) + (32'd1 << vsew_q)) <= 32'(ElenB)));
    end

    assign port_valid_o = valid_q;
    assign port_last_o  = last_q;
    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q == RUN);
    assign done_o       = done_q;

endmodule
